// File: rtl/png_chunk_chk.sv
// png_chunk_chk: parses a big-endian 32-bit PNG word stream, re-checks each
// chunk's CRC-32 over type+data, latches IHDR width/height and forwards the
// IDAT payload one byte per cycle.
module png_chunk_chk #(
  parameter int DATA_WD     = 32,
  parameter int SIZE_PIC_WD = 32
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   start_i,
  input  logic                   val_i,
  input  logic [DATA_WD-1:0]     dat_i,
  output logic                   rdy_o,
  output logic                   val_o,
  output logic [7:0]             dat_o,
  output logic                   chk_done_o,
  output logic                   crc_ok_o,
  output logic [31:0]            typ_o,
  output logic [SIZE_PIC_WD-1:0] w_o,
  output logic [SIZE_PIC_WD-1:0] h_o,
  output logic                   done_o,
  output logic                   err_o
);

  localparam logic [31:0] TYPE_IHDR = 32'h4948_4452;
  localparam logic [31:0] TYPE_IDAT = 32'h4944_4154;
  localparam logic [31:0] TYPE_IEND = 32'h4945_4E44;
  localparam logic [31:0] CRC_POLY  = 32'hEDB8_8320;

  typedef enum logic [2:0] {S_IDLE, S_SIG, S_LEN, S_TYPE, S_DATA, S_CRC} state_t;

  state_t             state_r, state_nx;
  logic [DATA_WD-1:0] buf_r;
  logic [2:0]         cnt_r;        // bytes still held in buf_r (0..4)
  logic [31:0]        byte_cnt_r;   // byte index within the current field
  logic [31:0]        len_r;
  logic [31:0]        crc_r;
  logic [31:0]        crc_rx_r;
  logic [7:0]         cur_byte;
  logic               consume;
  logic               accept;
  logic [31:0]        len_nx;
  logic [31:0]        rx_nx;
  logic [31:0]        crc_nx;
  logic               field_end;
  logic               set_err;
  logic               chk_fire;
  logic               crc_good;
  logic               fire_done;

  // Expected PNG signature byte at position idx.
  function automatic logic [7:0] sig_byte(input logic [2:0] idx);
    case (idx)
      3'd0:    sig_byte = 8'h89;
      3'd1:    sig_byte = 8'h50;
      3'd2:    sig_byte = 8'h4E;
      3'd3:    sig_byte = 8'h47;
      3'd4:    sig_byte = 8'h0D;
      3'd5:    sig_byte = 8'h0A;
      3'd6:    sig_byte = 8'h1A;
      default: sig_byte = 8'h0A;
    endcase
  endfunction

  // One byte of reflected CRC-32, eight bit steps unrolled.
  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
    return r;
  endfunction

  assign cur_byte = buf_r[DATA_WD-1 -: 8];
  assign consume  = (state_r != S_IDLE) && (cnt_r != 3'd0);
  // A new word may land in the same cycle the last buffered byte is used.
  assign rdy_o    = (state_r != S_IDLE) && ((cnt_r == 3'd0) || (consume && cnt_r == 3'd1));
  assign accept   = val_i && rdy_o;
  assign len_nx   = {len_r[23:0], cur_byte};
  assign rx_nx    = {crc_rx_r[23:0], cur_byte};
  assign crc_nx   = crc_step(crc_r, cur_byte);
  assign val_o    = consume && (state_r == S_DATA) && (typ_o == TYPE_IDAT);
  assign dat_o    = val_o ? cur_byte : 8'h00;

  // State register.
  // NOTE: sequential blocks use <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rstn) state_r <= S_IDLE;
    else       state_r <= state_nx;
  end

  // Next-state and per-byte field decisions.
  // NOTE: every signal gets a default first, so no path can infer a latch.
  always_comb begin
    state_nx  = state_r;
    field_end = 1'b0;
    set_err   = 1'b0;
    chk_fire  = 1'b0;
    crc_good  = 1'b0;
    fire_done = 1'b0;
    case (state_r)
      S_IDLE: if (start_i) state_nx = S_SIG;
      S_SIG: if (consume) begin
        if (cur_byte != sig_byte(byte_cnt_r[2:0])) begin
          set_err  = 1'b1;
          state_nx = S_IDLE;
        end else if (byte_cnt_r == 32'd7) begin
          field_end = 1'b1;
          state_nx  = S_LEN;
        end
      end
      S_LEN: if (consume && byte_cnt_r == 32'd3) begin
        field_end = 1'b1;
        if (len_nx[31]) begin
          set_err  = 1'b1;
          state_nx = S_IDLE;
        end else begin
          state_nx = S_TYPE;
        end
      end
      S_TYPE: if (consume && byte_cnt_r == 32'd3) begin
        field_end = 1'b1;
        state_nx  = (len_r != 32'd0) ? S_DATA : S_CRC;
      end
      S_DATA: if (consume && byte_cnt_r == len_r - 32'd1) begin
        field_end = 1'b1;
        state_nx  = S_CRC;
      end
      S_CRC: if (consume && byte_cnt_r == 32'd3) begin
        field_end = 1'b1;
        chk_fire  = 1'b1;
        crc_good  = (rx_nx == ~crc_r);
        set_err   = ~crc_good;
        if (typ_o == TYPE_IEND) begin
          state_nx  = S_IDLE;
          fire_done = crc_good;
        end else begin
          state_nx = S_LEN;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Byte buffer, field registers, CRC accumulator and output flags.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      buf_r      <= '0;
      cnt_r      <= 3'd0;
      byte_cnt_r <= 32'd0;
      len_r      <= 32'd0;
      crc_r      <= 32'hFFFF_FFFF;
      crc_rx_r   <= 32'd0;
      typ_o      <= 32'd0;
      w_o        <= '0;
      h_o        <= '0;
      chk_done_o <= 1'b0;
      crc_ok_o   <= 1'b0;
      done_o     <= 1'b0;
      err_o      <= 1'b0;
    end else begin
      // Leftover bytes are dropped whenever the parser falls back to IDLE.
      if (state_r != S_IDLE && state_nx == S_IDLE) begin
        buf_r <= '0;
        cnt_r <= 3'd0;
      end else if (accept) begin
        buf_r <= dat_i;
        cnt_r <= 3'd4;
      end else if (consume) begin
        buf_r <= {buf_r[DATA_WD-9:0], 8'h00};
        cnt_r <= cnt_r - 3'd1;
      end

      if (state_r == S_IDLE || field_end) byte_cnt_r <= 32'd0;
      else if (consume)                   byte_cnt_r <= byte_cnt_r + 32'd1;

      if (consume && state_r == S_LEN)  len_r    <= len_nx;
      if (consume && state_r == S_TYPE) typ_o    <= {typ_o[23:0], cur_byte};
      if (consume && state_r == S_CRC)  crc_rx_r <= rx_nx;

      if (state_r == S_LEN && state_nx == S_TYPE)
        crc_r <= 32'hFFFF_FFFF;
      else if (consume && (state_r == S_TYPE || state_r == S_DATA))
        crc_r <= crc_nx;

      if (consume && state_r == S_DATA && typ_o == TYPE_IHDR) begin
        if (byte_cnt_r < 32'd4)      w_o <= {w_o[SIZE_PIC_WD-9:0], cur_byte};
        else if (byte_cnt_r < 32'd8) h_o <= {h_o[SIZE_PIC_WD-9:0], cur_byte};
      end

      chk_done_o <= chk_fire;
      crc_ok_o   <= chk_fire & crc_good;
      done_o     <= fire_done;

      if (state_r == S_IDLE && start_i) err_o <= 1'b0;
      else if (set_err)                 err_o <= 1'b1;
    end
  end

endmodule
